// File: rtl/note_tone_gen.sv
// Square-wave tone generator fed by the one-hot note decoder.
// Ports: clk, rst_n, enable, note_sel[8], err_clr -> tone, active, note_idx[3], err.
module note_tone_gen #(
  parameter int CLK_HZ    = 1000000,
  parameter int DIV_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] note_sel,
  input  logic       err_clr,
  output logic       tone,
  output logic       active,
  output logic [2:0] note_idx,
  output logic       err
);

  // Half-period length in clocks for each note bit.
  localparam int HALF [8] = '{
    CLK_HZ / (2 * 1047),
    CLK_HZ / (2 * 1175),
    CLK_HZ / (2 * 1319),
    CLK_HZ / (2 * 1397),
    CLK_HZ / (2 * 1568),
    CLK_HZ / (2 * 3520),
    CLK_HZ / (2 * 3951),
    CLK_HZ / (2 * 2093)
  };

  for (genvar g = 0; g < 8; g++) begin : g_chk
    if (HALF[g] < 2 ||
        longint'(HALF[g]) >= (longint'(1) << DIV_WIDTH)) begin : g_bad
      $error("note_tone_gen: half-period of note %0d out of range", g);
    end
  end

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [2:0]           sel_idx;
  logic                 req;
  logic                 multi;
  logic [DIV_WIDTH-1:0] half_sel;
  logic [DIV_WIDTH-1:0] half_cur;

  // Lowest set bit wins; scanning downward leaves it last.
  always_comb begin
    sel_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (note_sel[i]) sel_idx = 3'(i);
    end
  end

  assign req      = enable && (note_sel != 8'd0);
  assign multi    = (note_sel & (note_sel - 8'd1)) != 8'd0;
  assign half_sel = DIV_WIDTH'(HALF[sel_idx] - 1);
  assign half_cur = DIV_WIDTH'(HALF[note_idx] - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      tone     <= 1'b0;
      active   <= 1'b0;
      note_idx <= '0;
      err      <= 1'b0;
    end else begin
      // A new set outranks a clear on the same edge.
      if (enable && multi) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (req) begin
            note_idx <= sel_idx;
            cnt      <= half_sel;
            tone     <= 1'b1;
            active   <= 1'b1;
            state    <= PLAY;
          end
        end
        PLAY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (tone) begin
            tone <= 1'b0;
            cnt  <= half_cur;
          end else if (req) begin
            // Full period done: start the next note without a gap.
            note_idx <= sel_idx;
            cnt      <= half_sel;
            tone     <= 1'b1;
          end else begin
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen at the 1 MHz default.
// Checks half-period lengths, note change, stop, error flag and async reset.
module tb_note_tone_gen;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] note_sel;
  logic       err_clr;
  logic       tone;
  logic       active;
  logic [2:0] note_idx;
  logic       err;

  int tests;
  int fails;
  int n;

  note_tone_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .note_sel (note_sel),
    .err_clr  (err_clr),
    .tone     (tone),
    .active   (active),
    .note_idx (note_idx),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count negedges (including the current one) while tone stays high.
  task automatic meas_high(output int cnt_o);
    cnt_o = 0;
    while (tone === 1'b1 && cnt_o < 2000) begin
      cnt_o++;
      @(negedge clk);
    end
  endtask

  // Count negedges while in the low half of an active period.
  task automatic meas_low(output int cnt_o);
    cnt_o = 0;
    while (tone === 1'b0 && active === 1'b1 && cnt_o < 2000) begin
      cnt_o++;
      @(negedge clk);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    note_sel = 8'h00;
    err_clr  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tone", int'(tone), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_idx", int'(note_idx), 0);
    chk("rst_err", int'(err), 0);

    // Basic C6 tone
    rst_n    = 1'b1;
    @(negedge clk);
    enable   = 1'b1;
    note_sel = 8'h01;
    @(negedge clk);
    chk("c6_start_tone", int'(tone), 1);
    chk("c6_start_active", int'(active), 1);
    chk("c6_idx", int'(note_idx), 0);
    meas_high(n);
    chk("c6_high1", n, 477);
    meas_low(n);
    chk("c6_low1", n, 477);

    // Switch to A7 at cycle 100 of the high half
    n = 0;
    while (tone === 1'b1 && n < 2000) begin
      if (n == 100) note_sel = 8'h20;
      n++;
      @(negedge clk);
    end
    chk("chg_c6_high", n, 477);
    chk("chg_c6_idx", int'(note_idx), 0);
    meas_low(n);
    chk("chg_c6_low", n, 477);
    chk("a7_idx", int'(note_idx), 5);
    meas_high(n);
    chk("a7_high", n, 142);

    // Queue G6 during the low half, then stop during its high half
    note_sel = 8'h10;
    meas_low(n);
    chk("a7_low", n, 142);
    chk("g6_idx", int'(note_idx), 4);
    n = 0;
    while (tone === 1'b1 && n < 2000) begin
      if (n == 10) enable = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("g6_high", n, 318);
    meas_low(n);
    chk("g6_low", n, 318);
    chk("stop_tone", int'(tone), 0);
    chk("stop_active", int'(active), 0);
    chk("stop_idx", int'(note_idx), 4);
    repeat (20) @(negedge clk);
    chk("idle_tone", int'(tone), 0);
    chk("idle_active", int'(active), 0);

    // Multi-hot select: F6 plays, err sticky until clear with clean input
    chk("pre_err", int'(err), 0);
    enable   = 1'b1;
    note_sel = 8'h48;
    @(negedge clk);
    chk("mh_err_set", int'(err), 1);
    chk("mh_tone", int'(tone), 1);
    chk("mh_idx", int'(note_idx), 3);
    err_clr = 1'b1;
    @(negedge clk);
    chk("mh_set_wins", int'(err), 1);
    note_sel = 8'h08;
    @(negedge clk);
    chk("mh_err_clr", int'(err), 0);
    err_clr = 1'b0;
    n = 2;
    while (tone === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("f6_high", n, 357);

    // Queue D6 with a multi-hot pattern during the low half
    note_sel = 8'h06;
    meas_low(n);
    chk("f6_low", n, 357);
    chk("d6_idx", int'(note_idx), 1);
    chk("d6_err", int'(err), 1);
    note_sel = 8'h02;
    repeat (50) @(negedge clk);

    // Async reset mid high half
    rst_n = 1'b0;
    #1;
    chk("arst_tone", int'(tone), 0);
    chk("arst_active", int'(active), 0);
    chk("arst_err", int'(err), 0);
    chk("arst_idx", int'(note_idx), 0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("d6_restart_tone", int'(tone), 1);
    chk("d6_restart_idx", int'(note_idx), 1);
    meas_high(n);
    chk("d6_high", n, 425);

    // Zero select stays idle
    rst_n    = 1'b0;
    note_sel = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("zero_tone", int'(tone), 0);
    chk("zero_active", int'(active), 0);
    chk("zero_err", int'(err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
